cmp_arbiter: RTL and testbench

- Shares one registered magnitude-compare unit among NUM_REQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- A round-robin FSM grants one requester, captures its operands, and computes the {y, z} relation flags.
- It then holds the tagged result on a valid/ready response port. Sits in front of the compare datapath as its sequencer.

---
 rtl/cmp_arb_pkg.sv | 18 +
 rtl/cmp_arbiter_rel.sv | 30 +++
 rtl/cmp_arbiter.sv | 114 +++++++++++
 tb/tb_cmp_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and relation-flag encodings for the cmp_arbiter compare sequencer.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_arb_state_e;

    // {y, z} relation flags
    typedef logic [1:0] rel_t;

    localparam rel_t REL_GT   = 2'b10;
    localparam rel_t REL_LT   = 2'b01;
    localparam rel_t REL_EQ   = 2'b11;
    localparam rel_t REL_NONE = 2'b00;

endpackage

// File: rtl/cmp_arbiter_rel.sv
// Combinational magnitude compare producing {y, z} relation flags.
// Define CMP_ARBITER_SIGNED_EN to compare operands as two's-complement values.
module cmp_arbiter_rel
    import cmp_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output rel_t              rel_c
);

    always_comb begin
        rel_c = REL_EQ;
`ifdef CMP_ARBITER_SIGNED_EN
        if ($signed(a) > $signed(b)) begin
            rel_c = REL_GT;
        end else if ($signed(a) < $signed(b)) begin
            rel_c = REL_LT;
        end
`else
        if (a > b) begin
            rel_c = REL_GT;
        end else if (a < b) begin
            rel_c = REL_LT;
        end
`endif
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sequencer sharing one registered compare unit among NUM_REQ requesters.
// Build option: CMP_ARBITER_SIGNED_EN selects a signed compare (see cmp_arbiter_rel).
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_y,
    output logic                      rsp_z
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    cmp_arb_state_e    state;
    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic              any_valid;
    logic [ID_W-1:0]   sel;
    int unsigned       idx;
    rel_t              rel_c;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr; idx stays below NUM_REQ for any NUM_REQ.
    always_comb begin
        any_valid = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_valid[ID_W'(idx)]) begin
                any_valid = 1'b1;
                sel       = ID_W'(idx);
            end
        end
    end

    // Grant is combinational in IDLE so the handshake completes in the selection cycle.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && any_valid) begin
            req_ready[sel] = 1'b1;
        end
    end

    cmp_arbiter_rel #(
        .DATA_W (DATA_W)
    ) u_rel (
        .a     (op_a),
        .b     (op_b),
        .rel_c (rel_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            op_a           <= '0;
            op_b           <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            {rsp_y, rsp_z} <= REL_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= a_arr[sel];
                        op_b   <= b_arr[sel];
                        rsp_id <= sel;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    {rsp_y, rsp_z} <= rel_c;
                    rsp_valid      <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    // Result held until accepted; no new grant until back in IDLE.
                    if (rsp_ready) begin
                        rsp_valid      <= 1'b0;
                        {rsp_y, rsp_z} <= REL_NONE;
                        rr_ptr         <= (rsp_id == LAST_ID) ? '0 : rsp_id + ID_W'(1);
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter (NUM_REQ=4, DATA_W=8).
module tb_cmp_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ID_W    = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_y;
    logic                      rsp_z;

    int checks = 0;
    int errors = 0;

    cmp_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 32'h0102_0304;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_z} !== 5'b0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%0d yz=%b%b want all 0", rsp_valid, rsp_id, rsp_y, rsp_z);
        end
        req_valid = '0;
        rst       = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got ready=%b v=%b want 0000 0", req_ready, rsp_valid);
        end
    endtask

    // One isolated transaction from requester id with rsp_ready held high.
    task automatic run_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] want, input string tag);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        @(negedge clk);
        req_a = '0;
        req_b = '0;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid = exp_rdy;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s_grant got %b want %b", tag, req_ready, exp_rdy);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL %s_cmp_cycle got v=%b ready=%b want 0 0000", tag, rsp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(id)) begin
            errors++;
            $display("FAIL %s_rsp got v=%b id=%0d want 1 %0d", tag, rsp_valid, rsp_id, id);
        end
        checks++;
        if ({rsp_y, rsp_z} !== want) begin
            errors++;
            $display("FAIL %s_rel got %b%b want %b", tag, rsp_y, rsp_z, want);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept got v=%b want 0", tag, rsp_valid);
        end
    endtask

    task automatic test_single;
        run_txn(2, 8'h40, 8'h10, 2'b10, "req2_gt");
    endtask

    task automatic test_relations;
        run_txn(0, 8'd5, 8'd9, 2'b01, "req0_lt");
        run_txn(1, 8'd7, 8'd7, 2'b11, "req1_eq");
    endtask

    task automatic test_signed;
`ifdef CMP_ARBITER_SIGNED_EN
        run_txn(3, 8'hFF, 8'h01, 2'b01, "signed_ff_01");
`else
        run_txn(3, 8'hFF, 8'h01, 2'b10, "unsigned_ff_01");
`endif
    endtask

    task automatic test_rotation;
        logic [1:0] tbl [4];
        logic [3:0] exp_rdy;
        int         g;
        tbl = '{2'b01, 2'b11, 2'b10, 2'b10};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i);
            req_b[i*8 +: 8] = 8'd1;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            g       = (c / 3) % 4;
            exp_rdy = (c % 3 == 0) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rot_ready c=%0d got %b want %b", c, req_ready, exp_rdy);
            end
            if (c % 3 == 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || {rsp_y, rsp_z} !== tbl[g]) begin
                    errors++;
                    $display("FAIL rot_rsp c=%0d got v=%b id=%0d yz=%b%b want 1 %0d %b",
                             c, rsp_valid, rsp_id, rsp_y, rsp_z, g, tbl[g]);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        req_a = '0;
        req_b = '0;
        req_a[24 +: 8] = 8'h33;
        req_b[24 +: 8] = 8'h33;
        req_a[0 +: 8]  = 8'h10;
        req_b[0 +: 8]  = 8'h20;
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant got %b want 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_cmp_ready got %b want 0000", req_ready);
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || {rsp_y, rsp_z} !== 2'b11) begin
                errors++;
                $display("FAIL bp_hold s=%0d got v=%b id=%0d yz=%b%b want 1 3 11", s, rsp_valid, rsp_id, rsp_y, rsp_z);
            end
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_no_grant s=%0d got %b want 0000", s, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL bp_rise got v=%b id=%0d want 1 3", rsp_valid, rsp_id);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_wrap_grant got v=%b ready=%b want 0 0001", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_y, rsp_z} !== 2'b01) begin
            errors++;
            $display("FAIL bp_drain got v=%b id=%0d yz=%b%b want 1 0 01", rsp_valid, rsp_id, rsp_y, rsp_z);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain_accept got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_a = '0;
        req_b = '0;
        req_a[8 +: 8] = 8'h50;
        req_b[8 +: 8] = 8'h20;
        req_a[0 +: 8] = 8'h20;
        req_b[0 +: 8] = 8'h50;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rm_grant got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        checks++;
        if (rsp_id !== 2'd1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_cmp got id=%0d v=%b want 1 0", rsp_id, rsp_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_y, rsp_z} !== 9'b0) begin
            errors++;
            $display("FAIL rm_async got ready=%b v=%b id=%0d yz=%b%b want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_y, rsp_z);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_regrant got ready=%b v=%b want 0001 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_no_stale_rsp got v=%b want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_y, rsp_z} !== 2'b01) begin
            errors++;
            $display("FAIL rm_rsp got v=%b id=%0d yz=%b%b want 1 0 01", rsp_valid, rsp_id, rsp_y, rsp_z);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_accept got v=%b want 0", rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_relations();
        test_signed();
        test_rotation();
        test_backpressure();
        test_reset_mid();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
